// File: rtl/unplus_field_sequencer.sv
// Serialises eighteen packed fields of a 128-bit word, one per beat, resized to OUT_W bits.
// Fields 0-8 are signed (sign-extended); fields 9-17 are unsigned (zero-extended); wider fields truncate.
module unplus_field_sequencer #(
  parameter int OUT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [4:0]       out_idx,
  output logic             out_last,
  output logic             busy
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_EMIT = 1'b1;
  localparam logic [4:0] LAST_IDX = 5'd17;

  logic             state;
  logic [89:0]      word;
  logic [89:0]      src;
  logic [4:0]       sel_idx;
  logic [OUT_W-1:0] field_val [32];
  logic             unused_hi;

  assign unused_hi = ^in_data[127:90];
  assign in_ready  = (state == ST_IDLE);

  // The resize bank looks at the incoming word while idle so beat 0 can be registered on accept.
  assign src     = (state == ST_IDLE) ? in_data[89:0] : word;
  assign sel_idx = (state == ST_IDLE) ? 5'd0 : out_idx + 5'd1;

  for (genvar g = 0; g < 32; g++) begin : g_field
    if (g < 18) begin : g_real
      localparam int FW  = (g < 9) ? g + 1 : g - 8;
      localparam int OFF = ((FW - 1) * FW) / 2 + ((g < 9) ? 0 : 45);
      logic [FW-1:0] raw;
      assign raw = src[OFF+FW-1:OFF];
      if (OUT_W > FW) begin : g_ext
        if (g < 9) begin : g_sext
          assign field_val[g] = {{(OUT_W-FW){raw[FW-1]}}, raw};
        end else begin : g_zext
          assign field_val[g] = {{(OUT_W-FW){1'b0}}, raw};
        end
      end else if (OUT_W == FW) begin : g_same
        assign field_val[g] = raw;
      end else begin : g_trunc
        assign field_val[g] = raw[OUT_W-1:0];
      end
    end else begin : g_pad
      assign field_val[g] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      word      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= 5'd0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            state     <= ST_EMIT;
            word      <= in_data[89:0];
            out_valid <= 1'b1;
            busy      <= 1'b1;
            out_idx   <= 5'd0;
            out_data  <= field_val[sel_idx];
            out_last  <= 1'b0;
          end
        end
        ST_EMIT: begin
          // Flush wins over any handshake, including the final beat.
          if (flush) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_last  <= 1'b0;
          end else if (out_ready) begin
            if (out_idx == LAST_IDX) begin
              state     <= ST_IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
              out_last  <= 1'b0;
            end else begin
              out_idx  <= sel_idx;
              out_data <= field_val[sel_idx];
              out_last <= (sel_idx == LAST_IDX);
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          out_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unplus_field_sequencer.sv
// Randomised bench for unplus_field_sequencer, checked against an arithmetic field model.
module tb_unplus_field_sequencer;
  localparam int OUT_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [127:0]     in_data = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic [4:0]       out_idx;
  logic             out_last;
  logic             busy;

  int total = 0;
  int bad = 0;
  logic [OUT_W-1:0] beat_data [18];

  unplus_field_sequencer #(.OUT_W(OUT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  // Field i: width w, triangular offset, +45 for the unsigned group; value resized as a plain integer.
  function automatic logic [OUT_W-1:0] model_field(input logic [127:0] d, input int i);
    int w, off;
    logic [127:0] tmp;
    longint raw, val;
    w   = (i < 9) ? i + 1 : i - 8;
    off = ((w - 1) * w) / 2 + ((i < 9) ? 0 : 45);
    tmp = (d >> off) & ((128'd1 << w) - 128'd1);
    raw = longint'(tmp[63:0]);
    val = raw;
    if (i < 9 && raw[w-1]) val = raw - (64'sd1 <<< w);
    return val[OUT_W-1:0];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Streams one word; idx arguments of -1 disable stall/flush/reset injection.
  task automatic stream(input logic [127:0] d, input bit rnd_ready, input int stall_idx,
                        input int stall_len, input int flush_idx, input int reset_idx,
                        input bit flush_on_accept, output int cycles);
    int exp_idx, stalled;
    bit rdy, done;
    logic [OUT_W-1:0] want;
    cycles = 0; exp_idx = 0; stalled = 0; done = 0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL idle_in_ready got=%b want=1", in_ready); end
    in_valid = 1'b1; in_data = d; flush = flush_on_accept; out_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    while (!done) begin
      in_valid = 1'b1; in_data = rand128();
      want = model_field(d, exp_idx);
      total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL beat_valid idx=%0d got=%b want=1", exp_idx, out_valid); end
      total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("[TB] FAIL beat_busy idx=%0d busy=%b in_ready=%b want 1/0", exp_idx, busy, in_ready); end
      total++; if (out_idx !== 5'(exp_idx)) begin bad++; $display("[TB] FAIL beat_idx got=%0d want=%0d", out_idx, exp_idx); end
      total++; if (out_data !== want) begin bad++; $display("[TB] FAIL beat_data idx=%0d got=%h want=%h", exp_idx, out_data, want); end
      total++; if (out_last !== (exp_idx == 17)) begin bad++; $display("[TB] FAIL beat_last idx=%0d got=%b want=%b", exp_idx, out_last, exp_idx == 17); end
      beat_data[exp_idx] = out_data;
      if (exp_idx == reset_idx) begin
        rst_n = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0 || out_idx !== 5'd0 || out_data !== '0 || out_last !== 1'b0 || busy !== 1'b0)
          begin bad++; $display("[TB] FAIL mid_reset valid=%b idx=%0d data=%h last=%b busy=%b want all 0", out_valid, out_idx, out_data, out_last, busy); end
        rst_n = 1'b1; done = 1;
      end else if (exp_idx == flush_idx) begin
        flush = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; cycles++;
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0)
          begin bad++; $display("[TB] FAIL flush_exit valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy); end
        done = 1;
      end else begin
        if (rnd_ready) rdy = ($urandom_range(0, 3) != 0);
        else if (exp_idx == stall_idx && stalled < stall_len) begin rdy = 1'b0; stalled++; end
        else rdy = 1'b1;
        out_ready = rdy;
        @(posedge clk); #1;
        cycles++;
        if (rdy) begin
          if (exp_idx == 17) begin
            total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_last !== 1'b0 || busy !== 1'b0)
              begin bad++; $display("[TB] FAIL word_end valid=%b in_ready=%b last=%b busy=%b want 0/1/0/0", out_valid, in_ready, out_last, busy); end
            done = 1;
          end else exp_idx++;
        end
        if (!done && cycles > 200) begin
          total++; bad++; $display("[TB] FAIL stream_timeout cycles=%0d idx=%0d want<=200", cycles, exp_idx); done = 1;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = rand128();
    repeat (2) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0 || out_idx !== 5'd0 || out_data !== '0 || out_last !== 1'b0 || busy !== 1'b0)
      begin bad++; $display("[TB] FAIL reset_outputs valid=%b idx=%0d data=%h last=%b busy=%b want all 0", out_valid, out_idx, out_data, out_last, busy); end
    rst_n = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_idle in_ready=%b valid=%b want 1/0", in_ready, out_valid); end
  endtask

  task automatic test_extension();
    logic [127:0] d;
    int cyc;
    d = rand128(); d[5:3] = 3'b101; d[50:48] = 3'b101;
    stream(d, 0, -1, 0, -1, -1, 0, cyc);
    total++; if (beat_data[2] !== 6'h3D) begin bad++; $display("[TB] FAIL ext_signed got=%h want=3d", beat_data[2]); end
    total++; if (beat_data[11] !== 6'h05) begin bad++; $display("[TB] FAIL ext_unsigned got=%h want=05", beat_data[11]); end
    total++; if (cyc !== 18) begin bad++; $display("[TB] FAIL ext_cycles got=%0d want=18", cyc); end
  endtask

  task automatic test_truncation();
    logic [127:0] d;
    int cyc;
    d = rand128(); d[44:36] = 9'h1AB; d[89:81] = 9'h1AB;
    stream(d, 0, -1, 0, -1, -1, 0, cyc);
    total++; if (beat_data[8] !== 6'h2B) begin bad++; $display("[TB] FAIL trunc_signed got=%h want=2b", beat_data[8]); end
    total++; if (beat_data[17] !== 6'h2B) begin bad++; $display("[TB] FAIL trunc_unsigned got=%h want=2b", beat_data[17]); end
  endtask

  task automatic test_one_bit();
    logic [127:0] d;
    int cyc;
    logic [OUT_W-1:0] want;
    d = '0; d[0] = 1'b1; d[45] = 1'b1;
    stream(d, 0, -1, 0, -1, -1, 0, cyc);
    for (int i = 0; i < 18; i++) begin
      want = (i == 0) ? 6'h3F : (i == 9) ? 6'h01 : 6'h00;
      total++; if (beat_data[i] !== want) begin bad++; $display("[TB] FAIL one_bit idx=%0d got=%h want=%h", i, beat_data[i], want); end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    stream(rand128(), 0, 4, 3, -1, -1, 0, cyc);
    total++; if (cyc !== 21) begin bad++; $display("[TB] FAIL bp_cycles got=%0d want=21", cyc); end
  endtask

  task automatic test_flush();
    int cyc;
    stream(rand128(), 0, -1, 0, 7, -1, 0, cyc);
    stream(rand128(), 0, -1, 0, -1, -1, 0, cyc);
    total++; if (cyc !== 18) begin bad++; $display("[TB] FAIL flush_next_cycles got=%0d want=18", cyc); end
    stream(rand128(), 1, -1, 0, 17, -1, 0, cyc);
    stream(rand128(), 0, -1, 0, -1, -1, 1, cyc);
    total++; if (cyc !== 18) begin bad++; $display("[TB] FAIL flush_idle_cycles got=%0d want=18", cyc); end
  endtask

  task automatic test_reset_midstream();
    int cyc;
    stream(rand128(), 0, -1, 0, -1, 12, 0, cyc);
    stream(rand128(), 0, -1, 0, -1, -1, 0, cyc);
    total++; if (cyc !== 18) begin bad++; $display("[TB] FAIL post_reset_cycles got=%0d want=18", cyc); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    for (int n = 0; n < 8; n++) stream(rand128(), 1, -1, 0, -1, -1, 0, cyc);
    for (int n = 0; n < 3; n++) begin
      stream(rand128(), 0, -1, 0, -1, -1, 0, cyc);
      total++; if (cyc !== 18) begin bad++; $display("[TB] FAIL b2b_cycles got=%0d want=18", cyc); end
    end
  endtask

  initial begin
    test_reset();
    test_extension();
    test_truncation();
    test_one_bit();
    test_backpressure();
    test_flush();
    test_reset_midstream();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
